// File: rtl/serial_paralelo_if.sv
// Byte-stream bus between the serial line driver and the serial-to-parallel receiver.
// The master drives the serial line; the slave returns the recovered bytes and status.
interface serial_paralelo_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: MSB-first shift-in, comma-based byte alignment,
// lock after LOCK_COUNT aligned commas, then emits every non-comma byte.
module serial_paralelo #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    serial_paralelo_if.slave  bus
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BC_W   = 4;
    localparam logic [BC_W-1:0] LOCK_CNT = BC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BC_W-1:0]     bc_cnt;
    logic [BYTE_W-1:0]   data_q;
    logic                valid_q;
    logic                strobe_q;
    logic                active_q;

    // Byte that would be in the shift register after this edge.
    logic [BYTE_W-1:0]   nxt_c;
    logic                boundary_c;
    logic                is_comma_c;
    logic [BC_W-1:0]     bc_inc_c;

    assign nxt_c      = {sr[BYTE_W-2:0], bus.data_in};
    assign boundary_c = (bit_cnt == CNT_W'(7));
    assign is_comma_c = (nxt_c == COMMA);
    assign bc_inc_c   = bc_cnt + BC_W'(1);

    assign bus.data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.active      = active_q;

    // Alignment FSM, framing counters and registered outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state    <= SEARCH;
            sr       <= '0;
            bit_cnt  <= '0;
            bc_cnt   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            sr       <= nxt_c;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            strobe_q <= 1'b0;

            case (state)
                // Hunt for a comma at any bit offset; a hit re-phases the byte counter.
                SEARCH: begin
                    if (is_comma_c) begin
                        bit_cnt <= '0;
                        bc_cnt  <= BC_W'(1);
                        if (LOCK_CNT == BC_W'(1)) begin
                            state    <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    if (boundary_c) begin
                        if (is_comma_c) begin
                            bc_cnt <= bc_inc_c;
                            if (bc_inc_c == LOCK_CNT) begin
                                state    <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state  <= SEARCH;
                            bc_cnt <= '0;
                        end
                    end
                end

                // Locked: commas are idle fill and only clear valid.
                ACTIVE: begin
                    if (boundary_c) begin
                        if (is_comma_c) begin
                            valid_q <= 1'b0;
                        end else begin
                            data_q   <= nxt_c;
                            valid_q  <= 1'b1;
                            strobe_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed self-checking bench for serial_paralelo: reset, lock, data, idle fill,
// failed lock and mid-stream reset.
module tb_serial_paralelo;

    logic clk_32f;
    logic reset;
    int   errors;
    int   checks;
    int   strobe_cnt;

    serial_paralelo_if bus ();

    serial_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Drive one bit, let the DUT sample it, then settle 1 time unit past the edge.
    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
        if (bus.byte_strobe) strobe_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobe_cnt = 0;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    task automatic relock();
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (4) send_byte(8'hBC);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.data_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            checks++;
            if ({bus.data_out, bus.valid_out, bus.byte_strobe, bus.active} !== 11'h000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h required 000", i,
                         {bus.data_out, bus.valid_out, bus.byte_strobe, bus.active});
            end
        end
        #1;
        reset = 1'b1;
    endtask

    task automatic test_lock();
        logic exp_active;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(i[2:0] inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd7});
                exp_active = (k == 3 && i == 0);
                checks++;
                if (bus.active !== exp_active) begin
                    errors++;
                    $display("FAIL lock_active comma %0d bit %0d: got %b required %b",
                             k, i, bus.active, exp_active);
                end
            end
        end
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL lock_valid: got %b required 0", bus.valid_out);
        end
    endtask

    task automatic test_data();
        logic [7:0] vec [3];
        vec[0] = 8'hFF; vec[1] = 8'hEE; vec[2] = 8'hDD;
        for (int k = 0; k < 3; k++) begin
            send_byte(vec[k]);
            checks++;
            if (bus.data_out !== vec[k] || bus.valid_out !== 1'b1) begin
                errors++;
                $display("FAIL data_byte %0d: got %h/%b required %h/1",
                         k, bus.data_out, bus.valid_out, vec[k]);
            end
            checks++;
            if (bus.byte_strobe !== 1'b1 || strobe_cnt != 1) begin
                errors++;
                $display("FAIL data_strobe %0d: got last=%b count=%0d required last=1 count=1",
                         k, bus.byte_strobe, strobe_cnt);
            end
        end
        send_bit(1'b0);
        checks++;
        if (bus.byte_strobe !== 1'b0 || bus.data_out !== 8'hDD) begin
            errors++;
            $display("FAIL data_hold: got strobe=%b data=%h required strobe=0 data=dd",
                     bus.byte_strobe, bus.data_out);
        end
        for (int i = 0; i < 7; i++) send_bit(1'b0);
    endtask

    task automatic test_idle();
        relock();
        send_byte(8'hAA);
        checks++;
        if (bus.data_out !== 8'hAA || bus.valid_out !== 1'b1 || strobe_cnt != 1) begin
            errors++;
            $display("FAIL idle_aa: got %h/%b strobes=%0d required aa/1 strobes=1",
                     bus.data_out, bus.valid_out, strobe_cnt);
        end
        send_byte(8'hBC);
        checks++;
        if (bus.data_out !== 8'hAA || bus.valid_out !== 1'b0 || strobe_cnt != 0) begin
            errors++;
            $display("FAIL idle_bc: got %h/%b strobes=%0d required aa/0 strobes=0",
                     bus.data_out, bus.valid_out, strobe_cnt);
        end
        send_byte(8'hCC);
        checks++;
        if (bus.data_out !== 8'hCC || bus.valid_out !== 1'b1 || strobe_cnt != 1) begin
            errors++;
            $display("FAIL idle_cc: got %h/%b strobes=%0d required cc/1 strobes=1",
                     bus.data_out, bus.valid_out, strobe_cnt);
        end
    endtask

    task automatic test_failed_lock();
        logic [7:0] vec [7];
        logic       exp_active;
        vec[0] = 8'hBC; vec[1] = 8'hBC; vec[2] = 8'h55;
        for (int k = 3; k < 7; k++) vec[k] = 8'hBC;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(vec[k][i]);
                exp_active = (k == 6 && i == 0);
                checks++;
                if (bus.active !== exp_active || bus.valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL failed_lock byte %0d bit %0d: got active=%b valid=%b required active=%b valid=0",
                             k, i, bus.active, bus.valid_out, exp_active);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [7:0] b77;
        relock();
        send_byte(8'h12);
        checks++;
        if (bus.data_out !== 8'h12 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got %h/%b required 12/1", bus.data_out, bus.valid_out);
        end
        b77 = 8'h77;
        for (int i = 7; i >= 4; i--) send_bit(b77[i]);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.data_out, bus.valid_out, bus.byte_strobe, bus.active} !== 11'h000) begin
            errors++;
            $display("FAIL mid_reset_clear: got %h required 000",
                     {bus.data_out, bus.valid_out, bus.byte_strobe, bus.active});
        end
        @(posedge clk_32f);
        #1;
        reset = 1'b1;
        strobe_cnt = 0;
        for (int i = 3; i >= 0; i--) send_bit(b77[i]);
        send_byte(8'h77);
        send_byte(8'h12);
        checks++;
        if (bus.valid_out !== 1'b0 || bus.active !== 1'b0 || strobe_cnt != 0) begin
            errors++;
            $display("FAIL mid_no_output: got valid=%b active=%b strobes=%0d required 0/0/0",
                     bus.valid_out, bus.active, strobe_cnt);
        end
        repeat (4) send_byte(8'hBC);
        checks++;
        if (bus.active !== 1'b1 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_relock: got active=%b valid=%b required 1/0",
                     bus.active, bus.valid_out);
        end
        send_byte(8'h34);
        checks++;
        if (bus.data_out !== 8'h34 || bus.valid_out !== 1'b1 || strobe_cnt != 1) begin
            errors++;
            $display("FAIL mid_after: got %h/%b strobes=%0d required 34/1 strobes=1",
                     bus.data_out, bus.valid_out, strobe_cnt);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        strobe_cnt  = 0;
        reset       = 1'b0;
        bus.data_in = 1'b0;
        test_reset();
        test_lock();
        test_data();
        test_idle();
        test_failed_lock();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
